// File: rtl/dist_pkg.sv
// Shared types and constants for the distance-frame accumulator.
// The frame result struct is sized by the default CNT_W/SUM_W constants.
package dist_pkg;

  localparam int DIST_W    = 5;
  localparam logic [DIST_W-1:0] DIST_MAX = 5'h1F;
  localparam int CNT_W_DEF = 7;
  localparam int SUM_W_DEF = 11;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } dist_acc_state_e;

  typedef struct packed {
    logic [SUM_W_DEF-1:0] sum;
    logic [DIST_W-1:0]    min;
    logic [DIST_W-1:0]    max;
    logic [CNT_W_DEF-1:0] count;
    logic                 forced;
  } dist_frame_res_t;

  function automatic logic [DIST_W-1:0] dist_min(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DIST_W-1:0] dist_max(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dist_frame_accum_if.sv
// Sample-in / frame-result-out handshake bundle for dist_frame_accum.
// DIST_FRAME_ACCUM_THRESH_EN adds the thresh input and out_hits output.
interface dist_frame_accum_if #(
  parameter int CNT_W = 7,
  parameter int SUM_W = 11
) ();
  import dist_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [DIST_W-1:0] out_min;
  logic [DIST_W-1:0] out_max;
  logic [CNT_W-1:0]  out_count;
  logic              out_forced;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
  logic [DIST_W-1:0] thresh;
  logic [CNT_W-1:0]  out_hits;
`endif

  modport slave (
    input  in_valid, in_dist, in_last, out_ready,
`ifdef DIST_FRAME_ACCUM_THRESH_EN
    input  thresh,
    output out_hits,
`endif
    output in_ready, out_valid, out_sum, out_min, out_max, out_count, out_forced
  );

  modport master (
    output in_valid, in_dist, in_last, out_ready,
`ifdef DIST_FRAME_ACCUM_THRESH_EN
    output thresh,
    input  out_hits,
`endif
    input  in_ready, out_valid, out_sum, out_min, out_max, out_count, out_forced
  );

endinterface

// File: rtl/dist_sat_add.sv
// SUM_W-bit accumulator plus DIST_W-bit addend, clamped to all-ones on overflow.
// Assumes SUM_W >= DIST_W.
module dist_sat_add
  import dist_pkg::*;
#(
  parameter int SUM_W = 11
) (
  input  logic [SUM_W-1:0]  acc_i,
  input  logic [DIST_W-1:0] addend_i,
  output logic [SUM_W-1:0]  sum_o
);

  logic [SUM_W:0] wide_s;

  // One extra carry bit exposes the overflow to the clamp.
  always_comb begin
    wide_s = {1'b0, acc_i} + {{(SUM_W + 1 - DIST_W){1'b0}}, addend_i};
    if (wide_s[SUM_W]) begin
      sum_o = {SUM_W{1'b1}};
    end else begin
      sum_o = wide_s[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/dist_frame_accum.sv
// Groups distance samples into frames and reports sum/min/max/count per frame.
// Optional hit counter under DIST_FRAME_ACCUM_THRESH_EN.
module dist_frame_accum
  import dist_pkg::*;
#(
  parameter int MAX_FRAME = 64,
  parameter int CNT_W     = 7,
  parameter int SUM_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  dist_frame_accum_if.slave  bus
);

  dist_acc_state_e   state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sat_sum_s;
  logic [DIST_W-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc_s;
  logic              forced_q, forced_d;
  logic              in_ready_s, out_valid_s, accept_s, close_max_s;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic              hit_s;
  assign hit_s = (bus.in_dist >= bus.thresh);
`endif

  assign accept_s    = bus.in_valid & in_ready_s;
  assign count_inc_s = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign close_max_s = (count_inc_s == CNT_W'(MAX_FRAME));

  dist_sat_add #(.SUM_W(SUM_W)) u_sat_add (
    .acc_i    (sum_q),
    .addend_i (bus.in_dist),
    .sum_o    (sat_sum_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: close on in_last or on reaching MAX_FRAME; release on out_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: begin
        if (accept_s && (bus.in_last || close_max_s)) state_d = DONE;
        else                                          state_d = ACC;
      end
      DONE: begin
        if (bus.out_ready) state_d = ACC;
        else               state_d = DONE;
      end
      default: state_d = ACC;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      ACC:     in_ready_s  = 1'b1;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Accumulator next values: fold in accepted beats, clear when the result is taken.
  always_comb begin
    sum_d    = sum_q;
    min_d    = min_q;
    max_d    = max_q;
    count_d  = count_q;
    forced_d = forced_q;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
    hits_d   = hits_q;
`endif
    case (state_q)
      ACC: begin
        if (accept_s) begin
          sum_d    = sat_sum_s;
          count_d  = count_inc_s;
          min_d    = (count_q == '0) ? bus.in_dist : dist_min(min_q, bus.in_dist);
          max_d    = (count_q == '0) ? bus.in_dist : dist_max(max_q, bus.in_dist);
          forced_d = ~bus.in_last & close_max_s;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
          hits_d   = hits_q + {{(CNT_W-1){1'b0}}, hit_s};
`endif
        end else begin
          sum_d = sum_q;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          sum_d    = '0;
          min_d    = DIST_MAX;
          max_d    = '0;
          count_d  = '0;
          forced_d = 1'b0;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
          hits_d   = '0;
`endif
        end else begin
          sum_d = sum_q;
        end
      end
      default: begin
        sum_d    = '0;
        min_d    = DIST_MAX;
        max_d    = '0;
        count_d  = '0;
        forced_d = 1'b0;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
        hits_d   = '0;
`endif
      end
    endcase
  end

  // Accumulator registers; these drive the result outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      min_q    <= DIST_MAX;
      max_q    <= '0;
      count_q  <= '0;
      forced_q <= 1'b0;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
      hits_q   <= '0;
`endif
    end else begin
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
      count_q  <= count_d;
      forced_q <= forced_d;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
      hits_q   <= hits_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_sum    = sum_q;
  assign bus.out_min    = min_q;
  assign bus.out_max    = max_q;
  assign bus.out_count  = count_q;
  assign bus.out_forced = forced_q;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
  assign bus.out_hits   = hits_q;
`endif

endmodule

// File: tb/tb_dist_frame_accum.sv
// Directed bench for dist_frame_accum: frame table plus corner sequences on
// three instances (default, SUM_W=6, MAX_FRAME=1).
module tb_dist_frame_accum;
  import dist_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  dist_frame_accum_if #(.CNT_W(7), .SUM_W(11)) if0 ();
  dist_frame_accum_if #(.CNT_W(7), .SUM_W(6))  if1 ();
  dist_frame_accum_if #(.CNT_W(7), .SUM_W(11)) if2 ();

  dist_frame_accum #(.MAX_FRAME(64), .CNT_W(7), .SUM_W(11)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dist_frame_accum #(.MAX_FRAME(64), .CNT_W(7), .SUM_W(6))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dist_frame_accum #(.MAX_FRAME(1),  .CNT_W(7), .SUM_W(11)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    int             n;
    logic [3:0][4:0] d;
    int             sum;
    int             mn;
    int             mx;
    int             hits;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input int n, input int a, input int b, input int c,
                              input int e, input int sum, input int mn,
                              input int mx, input int hits);
    vec_t v;
    v.n    = n;
    v.d[0] = 5'(a);
    v.d[1] = 5'(b);
    v.d[2] = 5'(c);
    v.d[3] = 5'(e);
    v.sum  = sum;
    v.mn   = mn;
    v.mx   = mx;
    v.hits = hits;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic beat0(input logic [4:0] d, input logic last);
    int guard;
    guard = 0;
    if0.in_valid = 1'b1;
    if0.in_dist  = d;
    if0.in_last  = last;
    while (!if0.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("beat_ready", int'(if0.in_ready), 1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    if0.in_last  = 1'b0;
  endtask

  task automatic res0(input int sum, input int mn, input int mx, input int cnt,
                      input int forced, input int hits);
    chk("out_valid", int'(if0.out_valid), 1);
    chk("out_sum", int'(if0.out_sum), sum);
    chk("out_min", int'(if0.out_min), mn);
    chk("out_max", int'(if0.out_max), mx);
    chk("out_count", int'(if0.out_count), cnt);
    chk("out_forced", int'(if0.out_forced), forced);
`ifdef DIST_FRAME_ACCUM_THRESH_EN
    chk("out_hits", int'(if0.out_hits), hits);
`else
    if (hits < 0) $display("unexpected negative hit count");
`endif
  endtask

  task automatic drain0();
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
    chk("drain_valid", int'(if0.out_valid), 0);
    chk("drain_ready", int'(if0.in_ready), 1);
    chk("drain_count", int'(if0.out_count), 0);
    chk("drain_sum", int'(if0.out_sum), 0);
    chk("drain_min", int'(if0.out_min), 31);
    chk("drain_max", int'(if0.out_max), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.in_dist = 5'd0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_dist = 5'd0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_dist = 5'd0; if2.in_last = 1'b0; if2.out_ready = 1'b0;
`ifdef DIST_FRAME_ACCUM_THRESH_EN
    if0.thresh = 5'd10; if1.thresh = 5'd0; if2.thresh = 5'd0;
`endif

    vecs[0] = mk(3, 3, 17, 9, 0, 29, 3, 17, 1);
    vecs[1] = mk(1, 5, 0, 0, 0, 5, 5, 5, 0);
    vecs[2] = mk(4, 0, 31, 0, 31, 62, 0, 31, 2);
    vecs[3] = mk(4, 12, 12, 12, 12, 48, 12, 12, 4);
    vecs[4] = mk(3, 30, 1, 2, 0, 33, 1, 30, 1);
    vecs[5] = mk(3, 4, 10, 20, 0, 34, 4, 20, 2);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(if0.out_valid), 0);
    chk("rst_min", int'(if0.out_min), 31);
    chk("rst_max", int'(if0.out_max), 0);
    chk("rst_sum", int'(if0.out_sum), 0);
    chk("rst_count", int'(if0.out_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(if0.in_ready), 1);

    // Table of in_last-terminated frames.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        beat0(vecs[v].d[i], (i == vecs[v].n - 1) ? 1'b1 : 1'b0);
      end
      res0(vecs[v].sum, vecs[v].mn, vecs[v].mx, vecs[v].n, 0, vecs[v].hits);
      drain0();
    end

    // 64 beats of 31 without in_last force-close the frame.
    for (int i = 0; i < 64; i++) beat0(5'd31, 1'b0);
    chk("full_ready", int'(if0.in_ready), 0);
    res0(1984, 31, 31, 64, 1, 64);

    // Back-pressure: a pending 7 must not be consumed while the result is held.
    if0.in_valid = 1'b1; if0.in_dist = 5'd7; if0.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", int'(if0.in_ready), 0);
      chk("hold_sum", int'(if0.out_sum), 1984);
      chk("hold_count", int'(if0.out_count), 64);
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
    chk("release_ready", int'(if0.in_ready), 1);
    chk("release_count", int'(if0.out_count), 0);
    @(negedge clk);
    if0.in_valid = 1'b0; if0.in_last = 1'b0;
    res0(7, 7, 7, 1, 0, 0);
    drain0();

    // in_last on the 64th beat is not a forced close.
    for (int i = 0; i < 63; i++) beat0(5'd1, 1'b0);
    beat0(5'd1, 1'b1);
    res0(64, 1, 1, 64, 0, 0);
    drain0();

    // Reset mid-frame discards the partial sums.
    beat0(5'd9, 1'b0);
    beat0(5'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", int'(if0.out_count), 0);
    chk("midrst_sum", int'(if0.out_sum), 0);
    chk("midrst_min", int'(if0.out_min), 31);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat0(5'd5, 1'b1);
    res0(5, 5, 5, 1, 0, 0);

    // Reset mid-DONE drops the pending result.
    rst_n = 1'b0;
    #1;
    chk("donerst_valid", int'(if0.out_valid), 0);
    chk("donerst_ready", int'(if0.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SUM_W=6: ten beats of 31 saturate at 63.
    for (int i = 0; i < 10; i++) begin
      if1.in_valid = 1'b1; if1.in_dist = 5'd31; if1.in_last = (i == 9) ? 1'b1 : 1'b0;
      chk("sat_ready", int'(if1.in_ready), 1);
      @(negedge clk);
    end
    if1.in_valid = 1'b0; if1.in_last = 1'b0;
    chk("sat_valid", int'(if1.out_valid), 1);
    chk("sat_sum", int'(if1.out_sum), 63);
    chk("sat_count", int'(if1.out_count), 10);
    chk("sat_forced", int'(if1.out_forced), 0);

    // MAX_FRAME=1: every beat closes its own frame.
    if2.in_valid = 1'b1; if2.in_dist = 5'd6; if2.in_last = 1'b0;
    @(negedge clk);
    if2.in_valid = 1'b0;
    chk("mf1_valid", int'(if2.out_valid), 1);
    chk("mf1_ready", int'(if2.in_ready), 0);
    chk("mf1_sum", int'(if2.out_sum), 6);
    chk("mf1_count", int'(if2.out_count), 1);
    chk("mf1_forced", int'(if2.out_forced), 1);
    if2.out_ready = 1'b1;
    @(negedge clk);
    if2.out_ready = 1'b0;
    if2.in_valid = 1'b1; if2.in_dist = 5'd9; if2.in_last = 1'b1;
    @(negedge clk);
    if2.in_valid = 1'b0; if2.in_last = 1'b0;
    chk("mf1_last_sum", int'(if2.out_sum), 9);
    chk("mf1_last_forced", int'(if2.out_forced), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
